// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer
//   Streams a debug snapshot as a byte stream with valid/ready handshake:
//   header 0xA5, register file bytes 0..15, dmem_count data-memory bytes,
//   then imem_count instruction words (high byte first).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     dump request, sampled only in IDLE
//   dmem_base/dmem_count      data-memory window (latched on start)
//   imem_base/imem_count      instruction-memory window (latched on start)
//   debug_enable              held high while a dump is in progress
//   reg/dmem/imem_debug_addr  registered read addresses
//   reg/dmem/imem_debug_rdata combinational read data, sampled on load
//   out_data/out_valid/out_ready  byte stream
//   busy                      high in every non-IDLE state
//   done                      one-cycle pulse as the dump completes
module debug_dump_sequencer #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned D_ADDR_W = 12,
   parameter int unsigned INST_W   = 16,
   parameter int unsigned I_ADDR_W = 12
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [D_ADDR_W-1:0] dmem_base,
   input  logic [D_ADDR_W:0]   dmem_count,
   input  logic [I_ADDR_W-1:0] imem_base,
   input  logic [I_ADDR_W:0]   imem_count,
   output logic                debug_enable,
   output logic [3:0]          reg_debug_addr,
   input  logic [DATA_W-1:0]   reg_debug_rdata,
   output logic [D_ADDR_W-1:0] dmem_debug_addr,
   input  logic [DATA_W-1:0]   dmem_debug_rdata,
   output logic [I_ADDR_W-1:0] imem_debug_addr,
   input  logic [INST_W-1:0]   imem_debug_rdata,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      IDLE, HDR, REG, DMEM, IMEM_HI, IMEM_LO, FLUSH
   } state_t;

   localparam logic [D_ADDR_W:0]   D_CNT_ONE  = {{D_ADDR_W{1'b0}}, 1'b1};
   localparam logic [I_ADDR_W:0]   I_CNT_ONE  = {{I_ADDR_W{1'b0}}, 1'b1};
   localparam logic [D_ADDR_W-1:0] D_ADDR_ONE = {{(D_ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [I_ADDR_W-1:0] I_ADDR_ONE = {{(I_ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [7:0]          out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [3:0]          reg_addr_q, reg_addr_d;
   logic [D_ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [D_ADDR_W:0]   dmem_rem_q, dmem_rem_d;
   logic [I_ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [I_ADDR_W:0]   imem_rem_q, imem_rem_d;
   logic                load;
   state_t              after_reg, after_dmem;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         reg_addr_q  <= '0;
         dmem_addr_q <= '0;
         dmem_rem_q  <= '0;
         imem_addr_q <= '0;
         imem_rem_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         reg_addr_q  <= reg_addr_d;
         dmem_addr_q <= dmem_addr_d;
         dmem_rem_q  <= dmem_rem_d;
         imem_addr_q <= imem_addr_d;
         imem_rem_q  <= imem_rem_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      reg_addr_d  = reg_addr_q;
      dmem_addr_d = dmem_addr_q;
      dmem_rem_d  = dmem_rem_q;
      imem_addr_d = imem_addr_q;
      imem_rem_d  = imem_rem_q;

      // Empty sections are skipped by choosing the successor state up front.
      after_dmem = (imem_rem_q != '0) ? IMEM_HI : FLUSH;
      after_reg  = (dmem_rem_q != '0) ? DMEM : after_dmem;

      // A new byte may enter the output register whenever it is empty or
      // being consumed this cycle.
      load = (state_q != IDLE) && (state_q != FLUSH) &&
             (!out_valid_q || out_ready);

      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (load)                     out_valid_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = HDR;
               reg_addr_d  = '0;
               dmem_addr_d = dmem_base;
               dmem_rem_d  = dmem_count;
               imem_addr_d = imem_base;
               imem_rem_d  = imem_count;
            end
         end
         HDR: begin
            if (load) begin
               out_data_d = 8'hA5;
               state_d    = REG;
            end
         end
         REG: begin
            if (load) begin
               out_data_d = reg_debug_rdata[7:0];
               reg_addr_d = reg_addr_q + 4'd1;
               if (reg_addr_q == 4'hF) state_d = after_reg;
            end
         end
         DMEM: begin
            if (load) begin
               out_data_d  = dmem_debug_rdata[7:0];
               dmem_addr_d = dmem_addr_q + D_ADDR_ONE;
               dmem_rem_d  = dmem_rem_q - D_CNT_ONE;
               if (dmem_rem_q == D_CNT_ONE) state_d = after_dmem;
            end
         end
         IMEM_HI: begin
            if (load) begin
               out_data_d = imem_debug_rdata[15:8];
               state_d    = IMEM_LO;
            end
         end
         IMEM_LO: begin
            if (load) begin
               out_data_d  = imem_debug_rdata[7:0];
               imem_addr_d = imem_addr_q + I_ADDR_ONE;
               imem_rem_d  = imem_rem_q - I_CNT_ONE;
               state_d     = (imem_rem_q == I_CNT_ONE) ? FLUSH : IMEM_HI;
            end
         end
         FLUSH: begin
            if (!out_valid_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data        = out_data_q;
   assign out_valid       = out_valid_q;
   assign reg_debug_addr  = reg_addr_q;
   assign dmem_debug_addr = dmem_addr_q;
   assign imem_debug_addr = imem_addr_q;
   assign busy            = (state_q != IDLE);
   assign debug_enable    = (state_q != IDLE);
   // Last byte has been accepted; this is the final FLUSH cycle.
   assign done            = (state_q == FLUSH) && !out_valid_q;

endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, debug byte width; the stream is byte-wide.
REQ-002 SHALL have parameter D_ADDR_W, default 12, data memory address width.
REQ-003 SHALL have parameter INST_W, default 16, instruction width; exactly 2 bytes.
REQ-004 SHALL have parameter I_ADDR_W, default 12, instruction memory address width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1 system clock; reset_n input 1 async active-low reset.
REQ-006 SHALL have port start input 1: request a dump; sampled only in IDLE.
REQ-007 SHALL have port dmem_base input D_ADDR_W: first data address.
REQ-008 SHALL have port dmem_count input D_ADDR_W+1: data bytes to dump, 0..4096.
REQ-009 SHALL have port imem_base input I_ADDR_W: first instruction address.
REQ-010 SHALL have port imem_count input I_ADDR_W+1: instruction words to dump, 0..4096.
REQ-011 SHALL have port debug_enable output 1: drives subsystem debug_enable.
REQ-012 SHALL have port reg_debug_addr output 4, with reg_debug_rdata input DATA_W.
REQ-013 SHALL have port dmem_debug_addr output D_ADDR_W, with dmem_debug_rdata input DATA_W.
REQ-014 SHALL have port imem_debug_addr output I_ADDR_W, with imem_debug_rdata input INST_W.
REQ-015 SHALL have stream ports out_data output 8, out_valid output 1 and out_ready input 1, with valid/ready semantics.
REQ-016 SHALL have status ports busy output 1 and done output 1 (one-cycle pulse).

Function
REQ-017 SHALL implement the FSM states IDLE, HDR, REG, DMEM, IMEM_HI, IMEM_LO and FLUSH.
REQ-018 SHALL transition IDLE->HDR on start=1, latching base and count inputs; inputs are ignored afterwards.
REQ-019 SHALL define a load cycle as: state is not IDLE or FLUSH and (out_valid=0 or out_ready=1).
- A load registers the current byte into out_data, sets out_valid=1, and advances the state and address.
REQ-020 SHALL clear out_valid when out_valid=1, out_ready=1 and no load occurs; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 SHALL load the constant byte 0xA5 in HDR, then go to REG.
REQ-022 SHALL, in REG, load reg_debug_rdata for reg_debug_addr 0..15, one per load, then go to DMEM.
REQ-023 SHALL, in DMEM, load dmem_debug_rdata at address (dmem_base+i) mod 2^D_ADDR_W for i=0..dmem_count-1.
- If dmem_count=0, DMEM is skipped with no byte emitted.
REQ-024 SHALL, in IMEM_HI and IMEM_LO, emit imem_debug_rdata[15:8] then [7:0] for each word at (imem_base+j) mod 2^I_ADDR_W, j=0..imem_count-1.
- If imem_count=0, both IMEM states are skipped.
REQ-025 SHALL enter FLUSH after the last load and return to IDLE when out_valid falls to 0; done=1 for exactly that cycle.
REQ-026 SHALL emit exactly 17+dmem_count+2*imem_count bytes in order, with throughput of one byte per cycle when out_ready is held 1.
REQ-027 SHALL assert busy and debug_enable in every non-IDLE state; both SHALL be 0 in IDLE.
REQ-028 SHALL drive all debug address outputs from registers and hold them stable between loads; debug rdata SHALL be sampled combinationally in the load cycle.
REQ-029 SHALL ignore start when not in IDLE; start in the done cycle SHALL NOT begin a dump.
REQ-030 SHALL treat out_ready as don't-care while out_valid=0.

Reset
REQ-031 SHALL, on reset_n=0 at any time including mid-dump, immediately enter IDLE with out_valid=0, out_data=0, busy=0, done=0 and debug_enable=0.
REQ-032 SHALL clear all debug addresses and counters to 0 on reset, with no partial byte delivered after reset release.

Verification
REQ-033 SHALL cover: start, dmem_count=0, imem_count=0, out_ready=1 -> bytes A5 then regs 0..15, 17 bytes on consecutive cycles, done one cycle after the last byte.
REQ-034 SHALL cover: dmem_base=0xFFE, dmem_count=4 -> data bytes from addresses FFE, FFF, 000, 001 (wrap).
REQ-035 SHALL cover: imem_base=0x010, imem_count=2 with words 0x1234 and 0xABCD -> tail bytes 12 34 AB CD.
REQ-036 SHALL cover: out_ready toggled randomly, 20% duty -> identical byte sequence, out_data stable while stalled, no drop or duplicate.
REQ-037 SHALL cover: reset_n pulsed low mid-DMEM -> outputs at reset values asynchronously; next start restarts from header 0xA5.
REQ-038 SHALL cover: start pulsed while busy, and in the done cycle -> ignored; exactly one dump and one done pulse.
